// File: rtl/nrs_gold_seq_gen.sv
// Gold-sequence generator for the NB-IoT NRS: seeds x1/x2 from cinit, discards the
// warm-up plus offset, then hands out c(2m), c(2m+1) pairs over valid/ready.
module nrs_gold_seq_gen #(
  parameter int NC           = 1600,
  parameter int OFFSET_PAIRS = 109,
  parameter int NUM_PAIRS    = 2,
  parameter int CNT_W        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cinit_valid,
  input  logic [27:0] cinit,
  output logic        busy,
  output logic [1:0]  c_out,
  output logic        c_valid,
  input  logic        c_ready,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ADV_LOAD  = CNT_W'(NC / 2 + OFFSET_PAIRS - 1);
  localparam logic [CNT_W-1:0] EMIT_LOAD = CNT_W'(NUM_PAIRS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  // Bit 0 is the oldest sample, so each single shift appends the new sample at bit 30.
  function automatic logic [30:0] x1_step2(input logic [30:0] r);
    logic [30:0] s;
    s = {r[3] ^ r[0], r[30:1]};
    return {s[3] ^ s[0], s[30:1]};
  endfunction

  function automatic logic [30:0] x2_step2(input logic [30:0] r);
    logic [30:0] s;
    s = {r[3] ^ r[2] ^ r[1] ^ r[0], r[30:1]};
    return {s[3] ^ s[2] ^ s[1] ^ s[0], s[30:1]};
  endfunction

  state_t           state_r, state_s;
  logic [30:0]      x1_r, x1_s;
  logic [30:0]      x2_r, x2_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       c_out_r, pair_s;
  logic             c_valid_r, busy_r, done_r, done_s;

  // Next-state, LFSR advance and step-counter logic.
  always_comb begin
    state_s = state_r;
    x1_s    = x1_r;
    x2_s    = x2_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cinit_valid) begin
          x1_s    = 31'h0000_0001;
          x2_s    = {3'b000, cinit};
          cnt_s   = ADV_LOAD;
          state_s = ADVANCE;
        end else begin
          state_s = IDLE;
        end
      end
      ADVANCE: begin
        x1_s = x1_step2(x1_r);
        x2_s = x2_step2(x2_r);
        if (cnt_r == CNT_ZERO) begin
          cnt_s   = EMIT_LOAD;
          state_s = EMIT;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      EMIT: begin
        if (c_ready) begin
          x1_s = x1_step2(x1_r);
          x2_s = x2_step2(x2_r);
          if (cnt_r == CNT_ZERO) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    pair_s = {x1_s[1] ^ x2_s[1], x1_s[0] ^ x2_s[0]};
  end

  // State and output registers; the pair is captured from the post-step LFSR contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      x1_r      <= 31'd0;
      x2_r      <= 31'd0;
      cnt_r     <= CNT_ZERO;
      c_out_r   <= 2'b00;
      c_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      x1_r      <= x1_s;
      x2_r      <= x2_s;
      cnt_r     <= cnt_s;
      c_out_r   <= (state_s == EMIT) ? pair_s : 2'b00;
      c_valid_r <= (state_s == EMIT);
      busy_r    <= (state_s != IDLE);
      done_r    <= done_s;
    end
  end

  assign busy    = busy_r;
  assign c_out   = c_out_r;
  assign c_valid = c_valid_r;
  assign done    = done_r;

endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// Scoreboard bench for nrs_gold_seq_gen: expected pairs come from a bit-serial Gold
// sequence model and are checked by a monitor on every accepted pair.
module tb_nrs_gold_seq_gen;

  localparam int NC           = 1600;
  localparam int OFFSET_PAIRS = 109;
  localparam int NUM_PAIRS    = 2;
  localparam int CNT_W        = 10;
  localparam int LATENCY      = NC / 2 + OFFSET_PAIRS;
  localparam int SEQ_LEN      = NC + 2 * (OFFSET_PAIRS + NUM_PAIRS) + 40;

  logic        clk;
  logic        rst;
  logic        cinit_valid;
  logic [27:0] cinit;
  logic        busy;
  logic [1:0]  c_out;
  logic        c_valid;
  logic        c_ready;
  logic        done;

  int n_checks;
  int n_fail;
  logic [1:0] exp_q[$];

  nrs_gold_seq_gen #(
    .NC(NC), .OFFSET_PAIRS(OFFSET_PAIRS), .NUM_PAIRS(NUM_PAIRS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cinit_valid(cinit_valid), .cinit(cinit),
    .busy(busy), .c_out(c_out), .c_valid(c_valid), .c_ready(c_ready), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: {c(2m+1), c(2m)} for the given seed.
  function automatic logic [1:0] exp_pair(input logic [27:0] ci, input int m);
    bit x1[SEQ_LEN];
    bit x2[SEQ_LEN];
    logic [1:0] r;
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = (i < 28) ? ci[i] : 1'b0;
    end
    for (int n = 0; n + 31 < SEQ_LEN; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    r[0] = x1[2*m + NC] ^ x2[2*m + NC];
    r[1] = x1[2*m + 1 + NC] ^ x2[2*m + 1 + NC];
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted pair is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && c_valid && c_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pair_unexpected: got %0d expected none at %0t", c_out, $time);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (c_out !== e) begin
          n_fail++;
          $display("FAIL pair_value: got %b expected %b at %0t", c_out, e, $time);
        end
      end
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic issue(input logic [27:0] ci);
    cinit_valid = 1'b1;
    cinit       = ci;
    @(posedge clk); #1;
    cinit_valid = 1'b0;
    for (int p = 0; p < NUM_PAIRS; p++) exp_q.push_back(exp_pair(ci, OFFSET_PAIRS + p));
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (c_valid) break;
    end
    check("valid_latency", lat, exp_lat);
  endtask

  task automatic wait_done(input bit chain, input logic [27:0] nci);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_seen", int'(seen), 1);
    check("queue_drained", exp_q.size(), 0);
    if (chain) begin
      issue(nci);
      check("done_width", int'(done), 0);
      check("chain_busy", int'(busy), 1);
    end else begin
      @(posedge clk); #1;
      check("done_width", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
    end
  endtask

  task automatic run_seed(input logic [27:0] ci);
    c_ready = 1'b1;
    issue(ci);
    wait_valid(LATENCY);
    wait_done(1'b0, 28'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, int'({busy, c_valid, done, c_out}), 0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    cinit_valid = 1'b0;
    cinit       = 28'h0;
    c_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_reset_outputs("reset_idle");
      @(posedge clk); #1;
    end

    run_seed(28'h0000000);
    run_seed(28'h0001C01);
    run_seed(28'hFFFFFFF);

    // Backpressure: pair must hold while stalled.
    c_ready = 1'b0;
    issue(28'h0123456);
    wait_valid(LATENCY);
    for (int i = 0; i < 50; i++) begin
      check("stall_hold_1", int'({c_valid, c_out}), int'({1'b1, exp_q[0]}));
      @(posedge clk); #1;
    end
    c_ready = 1'b1;
    @(posedge clk); #1;
    c_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_hold_2", int'({c_valid, c_out, done}), int'({1'b1, exp_q[0], 1'b0}));
      @(posedge clk); #1;
    end
    c_ready = 1'b1;
    @(posedge clk); #1;
    c_ready = 1'b0;
    wait_done(1'b0, 28'h0);

    // Seed offered mid-ADVANCE is ignored; then a seed on the done cycle is taken.
    c_ready = 1'b1;
    issue(28'h0ABCDEF);
    repeat (300) @(posedge clk);
    #1;
    cinit_valid = 1'b1;
    cinit       = 28'h5555555;
    @(posedge clk); #1;
    cinit_valid = 1'b0;
    check("busy_ignore", int'(busy), 1);
    wait_valid(LATENCY - 301);
    wait_done(1'b1, 28'h7654321);
    wait_valid(LATENCY);
    wait_done(1'b0, 28'h0);

    // Reset mid-ADVANCE.
    issue(28'h1111111);
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_mid_advance");
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_outputs("idle_after_reset_1");

    // Reset one cycle into EMIT with the pair not accepted.
    c_ready = 1'b0;
    issue(28'h2222222);
    wait_valid(LATENCY);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_mid_emit");
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_outputs("idle_after_reset_2");

    run_seed(28'h3C3C3C3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
